// File: rtl/dcache_port_responder_pkg.sv
// Shared types for the D$ port: responder FSM states, request record and byte-strobe helper.
package dcache_port_responder_pkg;

  localparam int unsigned DC_ADDR_W = 64;
  localparam int unsigned DC_DATA_W = 64;
  localparam int unsigned DC_STRB_W = DC_DATA_W / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_XLATE,
    S_MREQ,
    S_MWAIT,
    S_RESP,
    S_DRAIN
  } dcresp_state_t;

  typedef struct packed {
    logic [DC_ADDR_W-1:0] addr;
    logic                 write;
    logic [DC_DATA_W-1:0] wdata;
    logic [1:0]           wlen;
  } dc_req_t;

  // Mask of 2**wlen bytes starting at addr_lo; bytes past the beat are dropped.
  function automatic logic [DC_STRB_W-1:0] wstrb_from(input logic [2:0] addr_lo,
                                                      input logic [1:0] wlen);
    logic [15:0] w_mask;
    w_mask = ((16'd1 << (5'd1 << wlen)) - 16'd1) << addr_lo;
    return w_mask[DC_STRB_W-1:0];
  endfunction

endpackage

// File: rtl/dcache_port_responder_store_formatter.sv
// Aligns low-justified store data into the 64-bit beat and builds its byte strobes.
module dcache_port_responder_store_formatter
  import dcache_port_responder_pkg::*;
(
  input  logic [2:0]           i_addr_lo,
  input  logic [1:0]           i_wlen,
  input  logic [DC_DATA_W-1:0] i_wdata,
  output logic [DC_DATA_W-1:0] o_wdata,
  output logic [DC_STRB_W-1:0] o_wstrb,
  output logic                 o_misaligned
);

  always_comb begin
    o_wdata      = i_wdata << {i_addr_lo, 3'b000};
    o_wstrb      = wstrb_from(i_addr_lo, i_wlen);
    o_misaligned = ({1'b0, i_addr_lo} + (4'd1 << i_wlen)) > 4'd8;
  end

endmodule

// File: rtl/dcache_port_responder.sv
// Blocking, uncached D$ responder: optional TLB lookup, one memory beat, one-cycle completion pulse.
module dcache_port_responder
  import dcache_port_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DC_ADDR_W,
  parameter int unsigned DATA_WIDTH = DC_DATA_W,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dc_en,
  input  logic [ADDR_WIDTH-1:0] dc_in_addr,
  input  logic                  dc_write_en,
  input  logic [DATA_WIDTH-1:0] dc_in_wdata,
  input  logic [1:0]            dc_in_wlen,
  output logic [DATA_WIDTH-1:0] dc_out_rdata,
  output logic                  dc_out_rvalid,
  output logic                  dc_out_write_done,
  output logic                  dc_out_page_fault,
  input  logic                  translate_en,
  output logic                  tlb_req_valid,
  output logic [ADDR_WIDTH-1:0] tlb_req_vaddr,
  input  logic                  tlb_resp_valid,
  input  logic [ADDR_WIDTH-1:0] tlb_resp_paddr,
  input  logic                  tlb_resp_fault,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic                  mem_req_write,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  output logic [STRB_WIDTH-1:0] mem_req_wstrb,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_rdata
);

  dcresp_state_t         r_state;
  dcresp_state_t         w_next;
  dc_req_t               r_req;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic                  r_fault;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] w_fmt_wdata;
  logic [STRB_WIDTH-1:0] w_fmt_wstrb;
  logic                  w_misaligned;

  dcache_port_responder_store_formatter u_fmt (
    .i_addr_lo    (r_paddr[2:0]),
    .i_wlen       (r_req.wlen),
    .i_wdata      (r_req.wdata),
    .o_wdata      (w_fmt_wdata),
    .o_wstrb      (w_fmt_wstrb),
    .o_misaligned (w_misaligned)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // dc_en low outside IDLE/RESP means MEM has flushed the request: finish any
  // outstanding handshake silently and return to IDLE without a pulse.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (dc_en) w_next = translate_en ? S_XLATE : S_MREQ;
      S_XLATE: if (tlb_resp_valid) begin
                 if (!dc_en)              w_next = S_IDLE;
                 else if (tlb_resp_fault) w_next = S_RESP;
                 else                     w_next = S_MREQ;
               end
      S_MREQ:  if (mem_req_ready) w_next = dc_en ? S_MWAIT : S_DRAIN;
               else if (!dc_en)   w_next = S_IDLE;
      S_MWAIT: if (mem_resp_valid) w_next = dc_en ? S_RESP : S_IDLE;
               else if (!dc_en)    w_next = S_DRAIN;
      S_RESP:  w_next = S_IDLE;
      S_DRAIN: if (mem_resp_valid) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req   <= '0;
      r_paddr <= '0;
      r_fault <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (r_state == S_IDLE && dc_en) begin
        r_req   <= '{addr: dc_in_addr, write: dc_write_en, wdata: dc_in_wdata, wlen: dc_in_wlen};
        r_paddr <= dc_in_addr;
        r_fault <= 1'b0;
      end
      if (r_state == S_XLATE && tlb_resp_valid) begin
        r_paddr <= tlb_resp_paddr;
        r_fault <= tlb_resp_fault;
      end
      if (r_state == S_MWAIT && mem_resp_valid && !r_req.write) r_rdata <= mem_resp_rdata;
    end
  end

  always_comb begin
    tlb_req_valid     = (r_state == S_XLATE);
    tlb_req_vaddr     = r_req.addr;
    mem_req_valid     = (r_state == S_MREQ);
    mem_req_addr      = {r_paddr[ADDR_WIDTH-1:3], 3'b000};
    mem_req_write     = r_req.write;
    mem_req_wdata     = w_fmt_wdata;
    mem_req_wstrb     = w_fmt_wstrb;
    dc_out_rdata      = r_rdata;
    dc_out_rvalid     = (r_state == S_RESP) && !r_req.write;
    dc_out_write_done = (r_state == S_RESP) && r_req.write;
    dc_out_page_fault = (r_state == S_RESP) && r_fault;
  end

  a_store_in_beat: assert property (@(posedge clk) disable iff (reset)
    (r_state == S_MREQ && r_req.write) |-> !w_misaligned)
    else $error("store crosses an 8-byte boundary; upper bytes dropped");

endmodule

// File: tb/tb_dcache_port_responder.sv
// Directed bench for dcache_port_responder with a cycle-stepped TLB/memory responder.
module tb_dcache_port_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        dc_en, dc_write_en, translate_en;
  logic [63:0] dc_in_addr, dc_in_wdata;
  logic [1:0]  dc_in_wlen;
  logic [63:0] dc_out_rdata;
  logic        dc_out_rvalid, dc_out_write_done, dc_out_page_fault;
  logic        tlb_req_valid, tlb_resp_valid, tlb_resp_fault;
  logic [63:0] tlb_req_vaddr, tlb_resp_paddr;
  logic        mem_req_valid, mem_req_ready, mem_req_write, mem_resp_valid;
  logic [63:0] mem_req_addr, mem_req_wdata, mem_resp_rdata;
  logic [7:0]  mem_req_wstrb;

  always #5 clk = ~clk;

  dcache_port_responder #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .STRB_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .dc_en(dc_en), .dc_in_addr(dc_in_addr),
    .dc_write_en(dc_write_en), .dc_in_wdata(dc_in_wdata), .dc_in_wlen(dc_in_wlen),
    .dc_out_rdata(dc_out_rdata), .dc_out_rvalid(dc_out_rvalid),
    .dc_out_write_done(dc_out_write_done), .dc_out_page_fault(dc_out_page_fault),
    .translate_en(translate_en), .tlb_req_valid(tlb_req_valid), .tlb_req_vaddr(tlb_req_vaddr),
    .tlb_resp_valid(tlb_resp_valid), .tlb_resp_paddr(tlb_resp_paddr),
    .tlb_resp_fault(tlb_resp_fault), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr), .mem_req_write(mem_req_write),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  typedef struct {
    logic        tr;
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  wlen;
    logic [63:0] word;
    logic [63:0] paddr;
    logic        fault;
    int          tdly;
    int          rdly;
    logic [63:0] e_maddr;
    logic [63:0] e_wdata;
    logic [7:0]  e_wstrb;
    int          e_lat;
  } vec_t;

  vec_t vt[10];

  int n_vec = 0, n_err = 0, n_chk = 0, cyc = 0;
  int ready_delay, tlb_delay, resp_delay;
  logic        k_fault;
  logic [63:0] k_paddr, k_word;
  int mreq_cnt, tlb_cnt, resp_cnt;
  bit hs_prev;
  int n_rv, n_wd, n_mreq, pulse_cyc, ready_cyc, resp_cyc;
  logic [63:0] cap_addr, cap_wdata, cap_vaddr, pulse_rdata;
  logic [7:0]  cap_wstrb;
  logic        cap_write, cap_valid, stable_ok, pulse_pf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    n_rv = 0; n_wd = 0; n_mreq = 0; cap_valid = 0; stable_ok = 1; cap_vaddr = '0;
    pulse_cyc = -1; ready_cyc = -1; resp_cyc = -1;
  endtask

  task automatic clear_resp();
    hs_prev = 0; resp_cnt = -1; mreq_cnt = 0; tlb_cnt = 0;
    mem_req_ready = 0; mem_resp_valid = 0; tlb_resp_valid = 0;
  endtask

  // One cycle: sample DUT at negedge, then drive the TLB/memory responses for the next edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (mem_req_valid) begin
      n_mreq++;
      if (!cap_valid) begin
        cap_valid = 1; cap_addr = mem_req_addr; cap_wdata = mem_req_wdata;
        cap_wstrb = mem_req_wstrb; cap_write = mem_req_write;
      end else if (mem_req_addr !== cap_addr || mem_req_wdata !== cap_wdata ||
                   mem_req_wstrb !== cap_wstrb || mem_req_write !== cap_write) begin
        stable_ok = 0;
      end
    end
    if (tlb_req_valid) cap_vaddr = tlb_req_vaddr;
    if (dc_out_rvalid) begin
      n_rv++; pulse_cyc = cyc; pulse_rdata = dc_out_rdata; pulse_pf = dc_out_page_fault;
    end
    if (dc_out_write_done) begin
      n_wd++; pulse_cyc = cyc; pulse_pf = dc_out_page_fault;
    end
    if (hs_prev) begin resp_cnt = resp_delay; hs_prev = 0; end
    mem_resp_valid = 0;
    mem_resp_rdata = k_word;
    if (resp_cnt == 0) begin mem_resp_valid = 1; resp_cyc = cyc; end
    if (resp_cnt >= 0) resp_cnt--;
    mem_req_ready = 0;
    if (mem_req_valid) begin
      mreq_cnt++;
      if (mreq_cnt > ready_delay) begin mem_req_ready = 1; ready_cyc = cyc; hs_prev = 1; end
    end else mreq_cnt = 0;
    tlb_resp_valid = 0;
    tlb_resp_paddr = k_paddr;
    tlb_resp_fault = k_fault;
    if (tlb_req_valid) begin
      tlb_cnt++;
      if (tlb_cnt > tlb_delay) tlb_resp_valid = 1;
    end else tlb_cnt = 0;
  endtask

  task automatic issue(input logic tr, input logic wr, input logic [63:0] a,
                       input logic [63:0] d, input logic [1:0] l);
    dc_en = 1; translate_en = tr; dc_write_en = wr; dc_in_addr = a; dc_in_wdata = d; dc_in_wlen = l;
  endtask

  task automatic run_vec(input vec_t v);
    int start;
    clear_mon();
    ready_delay = v.rdly; tlb_delay = v.tdly; resp_delay = 0;
    k_fault = v.fault; k_paddr = v.paddr; k_word = v.word;
    issue(v.tr, v.wr, v.addr, v.wdata, v.wlen);
    start = cyc;
    for (int i = 0; i < 60 && pulse_cyc < 0; i++) step();
    dc_en = 0;
    chki("completed", int'(pulse_cyc >= 0), 1);
    step();
    chki("rvalid_pulses", n_rv, v.wr ? 0 : 1);
    chki("wdone_pulses", n_wd, v.wr ? 1 : 0);
    chki("latency", pulse_cyc - start, v.e_lat);
    chk("page_fault", 64'(pulse_pf), 64'(v.fault));
    if (v.tr) chk("tlb_vaddr", cap_vaddr, v.addr);
    if (v.fault) chki("mem_req_cycles", n_mreq, 0);
    else begin
      chk("mem_addr", cap_addr, v.e_maddr);
      chk("mem_write", 64'(cap_write), 64'(v.wr));
      chki("mem_stable", int'(stable_ok), 1);
      chki("ready_to_done", pulse_cyc - ready_cyc, 2);
      if (v.wr) begin
        chk("mem_wdata", cap_wdata, v.e_wdata);
        chk("mem_wstrb", 64'(cap_wstrb), 64'(v.e_wstrb));
      end else chk("rdata", pulse_rdata, v.word);
    end
    n_vec++;
  endtask

  initial begin
    int start, p1;
    //       tr    wr    addr                   wdata                  wlen  word                   paddr                  flt   td rd e_maddr                e_wdata                e_wstrb lat
    vt[0] = '{1'b0, 1'b0, 64'h1004,             64'h0,                 2'd2, 64'h1122334455667788,  64'h0,                 1'b0, 0, 0, 64'h1000,             64'h0,                 8'h00, 3};
    vt[1] = '{1'b0, 1'b1, 64'h2003,             64'hAB,                2'd0, 64'h0,                 64'h0,                 1'b0, 0, 0, 64'h2000,             64'h00000000AB000000,  8'h08, 3};
    vt[2] = '{1'b1, 1'b0, 64'h50001234,         64'h0,                 2'd3, 64'h0,                 64'h0,                 1'b1, 3, 0, 64'h0,                64'h0,                 8'h00, 5};
    vt[3] = '{1'b0, 1'b0, 64'h3010,             64'h0,                 2'd3, 64'hDEADBEEFCAFEF00D,  64'h0,                 1'b0, 0, 5, 64'h3010,             64'h0,                 8'h00, 8};
    vt[4] = '{1'b1, 1'b1, 64'h40000006,         64'h1234,              2'd1, 64'h0,                 64'h8000000000000A06,  1'b0, 1, 0, 64'h8000000000000A00, 64'h1234000000000000,  8'hC0, 5};
    vt[5] = '{1'b0, 1'b1, 64'h5004,             64'h89ABCDEF,          2'd2, 64'h0,                 64'h0,                 1'b0, 0, 0, 64'h5000,             64'h89ABCDEF00000000,  8'hF0, 3};
    vt[6] = '{1'b0, 1'b1, 64'h6008,             64'h0102030405060708,  2'd3, 64'h0,                 64'h0,                 1'b0, 0, 0, 64'h6008,             64'h0102030405060708,  8'hFF, 3};
    vt[7] = '{1'b1, 1'b0, 64'h7007,             64'h0,                 2'd0, 64'h0F0E0D0C0B0A0908,  64'h90000F07,          1'b0, 0, 0, 64'h90000F00,         64'h0,                 8'h00, 4};
    vt[8] = '{1'b0, 1'b1, 64'h100A,             64'hBEEF,              2'd1, 64'h0,                 64'h0,                 1'b0, 0, 0, 64'h1008,             64'h00000000BEEF0000,  8'h0C, 3};
    vt[9] = '{1'b1, 1'b1, 64'h6000,             64'h77,                2'd0, 64'h0,                 64'h0,                 1'b1, 0, 0, 64'h0,                64'h0,                 8'h00, 2};

    reset = 1; dc_en = 0; translate_en = 0; dc_write_en = 0;
    dc_in_addr = '0; dc_in_wdata = '0; dc_in_wlen = '0;
    tlb_resp_paddr = '0; tlb_resp_fault = 0; mem_resp_rdata = '0;
    ready_delay = 0; tlb_delay = 0; resp_delay = 0; k_fault = 0; k_paddr = '0; k_word = '0;
    clear_resp();
    clear_mon();
    step(); step();
    chk("rst_rvalid", 64'(dc_out_rvalid), 64'd0);
    chk("rst_wdone", 64'(dc_out_write_done), 64'd0);
    chk("rst_pfault", 64'(dc_out_page_fault), 64'd0);
    chk("rst_tlb_req", 64'(tlb_req_valid), 64'd0);
    chk("rst_mem_req", 64'(mem_req_valid), 64'd0);
    chk("rst_rdata", dc_out_rdata, 64'd0);
    n_vec++;
    reset = 0;
    step();

    foreach (vt[i]) run_vec(vt[i]);

    // Load then store with dc_en held: the store is taken on the IDLE cycle right after RESP.
    clear_mon(); ready_delay = 0; tlb_delay = 0; resp_delay = 0;
    k_word = 64'hA5A5_0102_0304_5A5A;
    issue(1'b0, 1'b0, 64'h1004, 64'h0, 2'd2);
    start = cyc;
    for (int i = 0; i < 20 && n_rv == 0; i++) step();
    p1 = pulse_cyc;
    chki("atomic_load_lat", p1 - start, 3);
    chk("atomic_load_rdata", pulse_rdata, 64'hA5A5_0102_0304_5A5A);
    dc_write_en = 1; dc_in_wdata = 64'h55; dc_in_wlen = 2'd0; cap_valid = 0;
    for (int i = 0; i < 20 && n_wd == 0; i++) step();
    dc_en = 0;
    step();
    chki("atomic_gap", pulse_cyc - p1, 4);
    chki("atomic_rv", n_rv, 1);
    chki("atomic_wd", n_wd, 1);
    chk("atomic_maddr", cap_addr, 64'h1000);
    chk("atomic_wdata", cap_wdata, 64'h0000005500000000);
    chk("atomic_wstrb", 64'(cap_wstrb), 64'h10);
    n_vec++;

    // Flush while waiting on memory: response is drained, no pulse, rdata untouched.
    clear_mon(); resp_delay = 2; k_word = 64'h1111_1111_1111_1111;
    issue(1'b0, 1'b0, 64'h2000, 64'h0, 2'd3);
    step(); step();
    dc_en = 0;
    for (int i = 0; i < 10 && resp_cyc < 0; i++) step();
    chki("drain_resp_seen", int'(resp_cyc >= 0), 1);
    step();
    chki("drain_no_pulse", n_rv + n_wd, 0);
    chk("drain_rdata_kept", dc_out_rdata, 64'hA5A5_0102_0304_5A5A);
    resp_delay = 0; k_word = 64'h2222_3333_4444_5555;
    issue(1'b0, 1'b0, 64'h2008, 64'h0, 2'd3);
    start = cyc;
    for (int i = 0; i < 20 && n_rv == 0; i++) step();
    dc_en = 0;
    step();
    chki("post_drain_lat", pulse_cyc - start, 3);
    chk("post_drain_rdata", pulse_rdata, 64'h2222_3333_4444_5555);
    chki("post_drain_rv", n_rv, 1);
    n_vec++;

    // Flush before the memory handshake: request withdrawn the next cycle.
    clear_mon(); ready_delay = 10;
    issue(1'b0, 1'b1, 64'h3000, 64'h99, 2'd0);
    step();
    chk("mreq_abort_valid", 64'(mem_req_valid), 64'd1);
    dc_en = 0;
    step();
    chk("mreq_abort_dropped", 64'(mem_req_valid), 64'd0);
    step(); step();
    chki("mreq_abort_no_pulse", n_rv + n_wd, 0);
    chki("mreq_abort_no_hs", int'(ready_cyc >= 0), 0);
    n_vec++;

    // Async reset in MREQ clears outputs before the next clock edge.
    clear_mon(); ready_delay = 10;
    issue(1'b0, 1'b0, 64'h4000, 64'h0, 2'd3);
    step(); step();
    chk("rst_mid_pre", 64'(mem_req_valid), 64'd1);
    #2 reset = 1;
    #1;
    chk("rst_mid_mem_req", 64'(mem_req_valid), 64'd0);
    chk("rst_mid_rdata", dc_out_rdata, 64'd0);
    chk("rst_mid_pulses", 64'({dc_out_rvalid, dc_out_write_done, dc_out_page_fault, tlb_req_valid}), 64'd0);
    dc_en = 0;
    clear_resp();
    step();
    reset = 0;
    step();
    chk("rst_mid_idle", 64'(mem_req_valid), 64'd0);
    n_vec++;
    run_vec(vt[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dcache_port_responder.md
Name: dcache_port_responder

Overview:
- Responder end of the D$ interface driven by the MEM stage: accepts dc_en/addr/write/wdata/wlen, translates the address, issues one memory beat, returns rdata/rvalid or write_done with page_fault.
- Sits between MEM stage and the backing memory/TLB, in place of a full data cache. Blocking, uncached, one transaction in flight.

Parameters:
ADDR_WIDTH, 64, virtual and physical address width
DATA_WIDTH, 64, data beat width
STRB_WIDTH, DATA_WIDTH/8, byte-strobe width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
dc_en  in  1  request valid, held by MEM until rvalid/write_done
dc_in_addr  in  64  virtual byte address
dc_write_en  in  1  1=store, 0=load
dc_in_wdata  in  64  store data, low-aligned
dc_in_wlen  in  2  log2(bytes), 3=8 bytes
dc_out_rdata  out  64  aligned 64-bit word containing addr
dc_out_rvalid  out  1  one-cycle load-complete pulse
dc_out_write_done  out  1  one-cycle store-complete pulse
dc_out_page_fault  out  1  qualifies rvalid/write_done
translate_en  in  1  0 = bare mode, paddr=vaddr
tlb_req_valid  out  1  translation request
tlb_req_vaddr  out  64  address to translate
tlb_resp_valid  in  1  translation done, any later cycle
tlb_resp_paddr  in  64  physical address
tlb_resp_fault  in  1  translation fault
mem_req_valid  out  1  memory request
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  64  physical address, bits[2:0]=0
mem_req_write  out  1  store beat
mem_req_wdata  out  64  shifted store data
mem_req_wstrb  out  8  byte enables
mem_resp_valid  in  1  read data / write ack
mem_resp_rdata  in  64  read data

Behaviour:
- Reset (async): state IDLE. All valid/pulse outputs 0. dc_out_rdata 0. Latched request cleared.
- States: IDLE, XLATE, MREQ, MWAIT, RESP, DRAIN.
- IDLE: when dc_en=1, latch addr/write/wdata/wlen.
  - translate_en=1: go XLATE.
  - translate_en=0: paddr=addr; go MREQ.
- XLATE: tlb_req_valid=1 with latched vaddr, held until tlb_resp_valid.
  - On tlb_resp_valid with fault=1: go RESP with fault set; no memory access.
  - On tlb_resp_valid without fault: latch paddr, go MREQ.
- MREQ: mem_req_valid=1, with addr={paddr[63:3],3'b0}, write, wdata, wstrb stable until mem_req_ready. Then go MWAIT.
- MWAIT: on mem_resp_valid, latch rdata (loads only) and go RESP.
- RESP: exactly one cycle.
  - rvalid=1 (load) or write_done=1 (store); page_fault=fault flag; rdata=latched word (don't-care on fault).
  - Then go IDLE. dc_en is sampled again next cycle, so back-to-back requests (atomic read then write) cost no extra gap.
- Minimum latency, bare mode, ready and resp same-cycle-after: dc_en@T0, MREQ@T1, MWAIT@T2, RESP@T3.
- Store formatting:
  - wdata shifted left by addr[2:0]*8.
  - wstrb = ((1<<(1<<wlen))-1) << addr[2:0], truncated to 8 bits.
  - A request crossing an 8-byte boundary raises $error; upper bytes are dropped.
- Loads return the full aligned word; MEM does the shift and extension.
- Abort: dc_en=0 in XLATE/MREQ/MWAIT (trap/flush).
  - XLATE: wait for tlb_resp_valid, then IDLE.
  - MREQ: if mem_req_ready is not yet seen, drop valid and go IDLE. A request already handshaken goes to DRAIN.
  - MWAIT/DRAIN: wait for mem_resp_valid, discard it, go IDLE.
  - No rvalid/write_done is emitted for an aborted request.
  - Aborted stores that reached memory are not undone.
- New dc_en while in DRAIN is ignored until IDLE.
- Latched request fields are not re-sampled mid-transaction; address changes while dc_en is held are ignored.
- Reset mid-operation: immediate return to IDLE. Outstanding memory responses after reset are ignored; the memory model is reset alongside.

Decomposition:
- Shared package gets:
  - dcresp_state_t enum.
  - A byte-strobe function wstrb_from(addr_lo, wlen).
  - The D$ port request struct (addr, write, wdata, wlen) so MEM stage and responder share one definition.
- Sub-module: store_formatter (combinational shift + strobe + misalignment flag). Everything else stays in one FSM module.

Test Plan:
- Bare load: translate_en=0, addr=0x1004, wlen=2, memory word 0x1122334455667788 -> mem_req_addr=0x1000, write=0; one rvalid pulse at T3 with rdata=0x1122334455667788, page_fault=0.
- Byte store: addr=0x2003, wlen=0, wdata=0xAB -> mem_req_wdata=0x00000000AB000000, wstrb=0x08; single write_done pulse, no rvalid.
- Translated fault: translate_en=1, tlb_resp_fault=1 after 3 cycles -> no mem_req_valid ever; rvalid=1 with page_fault=1 for one cycle.
- Backpressure: mem_req_ready low 5 cycles -> mem_req_* stable all 5 cycles; completion exactly 2 cycles after ready.
- Atomic pair: load completes, dc_en stays high with write_en=1 next cycle -> second transaction accepted with no idle gap; write_done follows.
- Abort: dc_en drops in MWAIT -> response discarded, no pulses; a new load 1 cycle after mem_resp_valid completes normally. Async reset asserted in MREQ -> all outputs 0 within the reset cycle.
